// File: rtl/cpu_phase_seq_if.sv
// Control and beat-code bundle between the CPU timing unit and the phase
// sequencer that drives the 2-to-4 beat decoder.
interface cpu_phase_seq_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stop;
    logic             Step_mode;
    logic             Halt;
    logic             Wait;
    logic             Ph_I0;
    logic             Ph_I1;
    logic             Ph_en;
    logic             Run;
    logic             Cyc_done;
    logic [CNT_W-1:0] Cyc_cnt;
    logic             Timeout;

    modport master (
        output Start, Stop, Step_mode, Halt, Wait,
        input  Ph_I0, Ph_I1, Ph_en, Run, Cyc_done, Cyc_cnt, Timeout
    );

    modport slave (
        input  Start, Stop, Step_mode, Halt, Wait,
        output Ph_I0, Ph_I1, Ph_en, Run, Cyc_done, Cyc_cnt, Timeout
    );
endinterface

// File: rtl/cpu_phase_seq.sv
// Beat sequencer: walks T0..T3 for the phase decoder, with run/stop/halt,
// single-step, T2 wait-state stretching and a completed-cycle counter.
module cpu_phase_seq #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic            Clk,
    input  logic            Rst_n,
    cpu_phase_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP_WAIT,
        HALTED
    } state_t;

    localparam logic [7:0]       WMAX = 8'(WAIT_MAX);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [1:0]       phase;
    logic             stop_pend;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             timeout;
    logic             run;

    // Sequencer FSM; phase is only non-zero while running.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            stop_pend <= 1'b0;
            wait_cnt  <= 8'd0;
            cyc_cnt   <= '0;
            timeout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start && !bus.Stop) begin
                        state <= RUN;
                        phase <= 2'd0;
                    end
                end
                RUN: begin
                    if (bus.Stop) begin
                        stop_pend <= 1'b1;
                    end
                    case (phase)
                        2'd2: begin
                            if (!bus.Wait) begin
                                wait_cnt <= 8'd0;
                                phase    <= 2'd3;
                            end else if (wait_cnt == WMAX) begin
                                // Memory never answered: give up.
                                state     <= HALTED;
                                timeout   <= 1'b1;
                                phase     <= 2'd0;
                                wait_cnt  <= 8'd0;
                                stop_pend <= 1'b0;
                            end else begin
                                wait_cnt <= wait_cnt + 8'd1;
                            end
                        end
                        2'd3: begin
                            cyc_cnt <= cyc_cnt + ONE;
                            phase   <= 2'd0;
                            if (bus.Halt) begin
                                state     <= HALTED;
                                stop_pend <= 1'b0;
                            end else if (stop_pend || bus.Stop) begin
                                state     <= IDLE;
                                stop_pend <= 1'b0;
                            end else if (bus.Step_mode) begin
                                state <= STEP_WAIT;
                            end
                        end
                        default: begin
                            phase <= phase + 2'd1;
                        end
                    endcase
                end
                STEP_WAIT: begin
                    if (bus.Stop) begin
                        state <= IDLE;
                    end else if (bus.Start) begin
                        state <= RUN;
                        phase <= 2'd0;
                    end
                end
                HALTED: begin
                    if (bus.Stop) begin
                        state <= IDLE;
                    end else if (bus.Start) begin
                        state   <= RUN;
                        phase   <= 2'd0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign run          = (state == RUN);
    assign bus.Ph_I0    = phase[1];
    assign bus.Ph_I1    = phase[0];
    assign bus.Ph_en    = run;
    assign bus.Run      = run;
    assign bus.Cyc_done = run && (phase == 2'd3);
    assign bus.Cyc_cnt  = cyc_cnt;
    assign bus.Timeout  = timeout;
endmodule
